// File: rtl/reg_bank_rw.sv
// reg_bank_rw: 32 x DATA_W MIPS general register bank.
// One write port, two registered read ports with write-first bypass,
// plus live views of $sp (r29) and $ra (r31).
module reg_bank_rw #(
  parameter int SP_INIT = 227,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [4:0]        write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [4:0]        read_reg1,
  input  logic [4:0]        read_reg2,
  input  logic              load_ab,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [DATA_W-1:0] sp_value,
  output logic [DATA_W-1:0] ra_value,
  output logic              write_ack
);

  localparam logic [DATA_W-1:0] SP_RESET = DATA_W'(SP_INIT);

  // r0 has no storage; only r1..r31 are real registers.
  logic [DATA_W-1:0] regs_reg [1:31];
  // Full 32-entry view with r0 hard-wired to zero.
  logic [DATA_W-1:0] regs_view [32];

  logic [DATA_W-1:0] read_data1_reg, read_data2_reg;
  logic [DATA_W-1:0] op1_next, op2_next;
  logic              write_ack_reg;
  logic              commit;

  // A write to r0 is dropped and never acknowledged.
  assign commit = reg_write && (write_reg != 5'd0);

  assign regs_view[0] = '0;

  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_reg
      // Per-register storage; r29 comes out of reset holding the initial stack pointer.
      always_ff @(posedge clk) begin
        if (reset)
          regs_reg[gi] <= (gi == 29) ? SP_RESET : '0;
        else if (reg_write && (write_reg == 5'(gi)))
          regs_reg[gi] <= write_data;
      end
      assign regs_view[gi] = regs_reg[gi];
    end
  endgenerate

  // Operand selection with write-first bypass so a same-edge write is seen by the read.
  always_comb begin
    op1_next = '0;
    op2_next = '0;
    if (read_reg1 != 5'd0)
      op1_next = (reg_write && (write_reg == read_reg1)) ? write_data : regs_view[read_reg1];
    if (read_reg2 != 5'd0)
      op2_next = (reg_write && (write_reg == read_reg2)) ? write_data : regs_view[read_reg2];
  end

  // Registered A/B operands (captured only on load_ab) and the write acknowledge pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data1_reg <= '0;
      read_data2_reg <= '0;
      write_ack_reg  <= 1'b0;
    end else begin
      write_ack_reg <= commit;
      if (load_ab) begin
        read_data1_reg <= op1_next;
        read_data2_reg <= op2_next;
      end
    end
  end

  assign read_data1 = read_data1_reg;
  assign read_data2 = read_data2_reg;
  assign write_ack  = write_ack_reg;
  assign sp_value   = regs_view[29];
  assign ra_value   = regs_view[31];

endmodule

// File: doc/reg_bank_rw.md
Name: reg_bank_rw

Overview:
- 32 x 32-bit MIPS general register bank.
- Consumes the destination-register index produced by the write-destination select stage (rs/rt/rd/29/31) together with write-back data.
- Supplies operands to the multicycle datapath through registered A/B read outputs.
- Also exports the live $sp (r29) and $ra (r31) values for stack and return-address logic.

Parameters:
- SP_INIT, 227, value loaded into r29 ($sp) on reset.
- DATA_W, 32, register width in bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- reg_write  input  1  write enable for the write port.
- write_reg  input  5  destination register index (from write-destination select).
- write_data  input  DATA_W  write-back data.
- read_reg1  input  5  source index A (instr[25:21]).
- read_reg2  input  5  source index B (instr[20:16]).
- load_ab  input  1  capture enable for the A/B read outputs.
- read_data1  output  DATA_W  registered operand A.
- read_data2  output  DATA_W  registered operand B.
- sp_value  output  DATA_W  combinational view of r29.
- ra_value  output  DATA_W  combinational view of r31.
- write_ack  output  1  registered pulse: a write was committed in the previous cycle.

Behaviour:
- Single clock domain; all state updates on the rising edge of clk. Reset is synchronous, active-high, and has priority over every other input.
- Reset values:
  - r0..r31 = 0, except r29 = SP_INIT.
  - read_data1 = 0, read_data2 = 0, write_ack = 0.
  - After the reset edge, sp_value = SP_INIT and ra_value = 0.
- Write port:
  - At an edge with reset=0, reg_write=1 and write_reg!=0: regs[write_reg] <= write_data, and write_ack <= 1.
  - Otherwise no array change and write_ack <= 0.
  - A write to r0 is discarded and gives write_ack = 0.
  - r0 always reads 0.
- Read port, 1-cycle latency:
  - At an edge with reset=0 and load_ab=1, read_data1 and read_data2 are each loaded with the operand selected below.
  - With load_ab=0 both outputs hold their value.
- Operand selection (applies independently to each port):
  - Index 0 gives 0.
  - If reg_write=1 and write_reg equals the index (nonzero) in the same cycle, write_data is captured (write-first bypass).
  - Otherwise the current regs[index] is captured.
- Both ports may name the same register; both then receive the identical value, including the bypass case.
- sp_value and ra_value:
  - Combinational from the array; they reflect a write in the cycle after its edge.
  - They are not affected by load_ab.
- Arithmetic: none. Data passes through unmodified at full DATA_W. Indices are 5 bits, so every index is in range.
- Reset asserted together with reg_write and/or load_ab: reset wins, so no write is committed and outputs go to reset values.
- Reset mid-sequence: any previously written contents are lost; r29 returns to SP_INIT.
- Simultaneous write and load_ab to different registers: the write commits and the reads capture pre-edge contents of their own indices.
- Simultaneous write with load_ab=0: the write commits and read outputs hold.

Test Plan:
- Reset, then read_reg1=29, read_reg2=31, load_ab=1 for 1 cycle -> read_data1=227, read_data2=0, sp_value=227, ra_value=0, write_ack=0.
- Write r8=0xDEADBEEF (reg_write=1 for 1 cycle), next cycle read_reg1=8 with load_ab=1 -> write_ack=1 in the cycle after the write, and read_data1=0xDEADBEEF after the load edge.
- Write r0=0xFFFFFFFF, then read r0 on both ports -> both read 0 and write_ack stays 0.
- Same edge: reg_write=1, write_reg=5, write_data=0x12345678, read_reg1=read_reg2=5, load_ab=1 -> both outputs 0x12345678 (bypass) after that edge.
- Write r31=0x00400020 with load_ab=0 -> read_data1/read_data2 unchanged and ra_value=0x00400020 the following cycle. Write r29=200 -> sp_value=200.
- Write r29=100, then assert reset together with reg_write=1, write_reg=29, write_data=5 -> sp_value=227, all read outputs 0, write_ack=0.
